// File: rtl/rgb_pwm_pkg.sv
// ============================================================================
// Module      : rgb_pwm_pkg
// Description : Shared duty-width constant and PWM period derivation.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rgb_pwm_pkg;

    localparam int c_duty_width = 8;

    // Period in clock cycles for a counter of the given width.
    function automatic int pwm_period(input int width);
        return 1 << width;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rgb_pwm_if.sv
// ============================================================================
// Module      : rgb_pwm_if
// Description : Duty/enable inputs and PWM/period-marker outputs of rgb_pwm.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface rgb_pwm_if #(
    parameter int WIDTH = rgb_pwm_pkg::c_duty_width
);
    logic             enable;
    logic [WIDTH-1:0] duty_r;
    logic [WIDTH-1:0] duty_g;
    logic [WIDTH-1:0] duty_b;
    logic             pwm_r;
    logic             pwm_g;
    logic             pwm_b;
    logic             period_start;

    modport master (
        output enable, duty_r, duty_g, duty_b,
        input  pwm_r, pwm_g, pwm_b, period_start
    );

    modport slave (
        input  enable, duty_r, duty_g, duty_b,
        output pwm_r, pwm_g, pwm_b, period_start
    );
endinterface

`default_nettype wire

// File: rtl/rgb_pwm_channel.sv
// ============================================================================
// Module      : pwm_channel
// Description : One colour channel: shadow/active duty buffering and compare.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pwm_channel #(
    parameter int WIDTH = 8
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic             i_enable,
    input  wire logic             i_wrap,
    input  wire logic [WIDTH-1:0] i_count,
    input  wire logic [WIDTH-1:0] i_duty,
    output logic                  o_pwm
);

    logic [WIDTH-1:0] r_shadow;
    logic [WIDTH-1:0] r_active;
    logic             r_pwm;

    // Active duty only moves at the wrap (or while parked) so a period is never cut short.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_shadow <= '0;
            r_active <= '0;
            r_pwm    <= 1'b0;
        end else begin
            r_shadow <= i_duty;
            if (!i_enable || i_wrap) begin
                r_active <= r_shadow;
            end
            r_pwm <= i_enable && (i_count < r_active);
        end
    end

    assign o_pwm = r_pwm;

endmodule

`default_nettype wire

// File: rtl/rgb_pwm.sv
// ============================================================================
// Module      : rgb_pwm
// Description : Three-channel phase-aligned PWM driver for the R/G/B LED pins.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rgb_pwm
    import rgb_pwm_pkg::*;
#(
    parameter int WIDTH = c_duty_width
) (
    input  wire logic clk,
    input  wire logic reset,
    rgb_pwm_if.slave  bus
);

    localparam int               c_period    = pwm_period(WIDTH);
    localparam logic [WIDTH-1:0] c_count_max = WIDTH'(c_period - 1);

    logic [WIDTH-1:0] r_count;
    logic             r_period_start;
    logic             w_wrap;

    assign w_wrap = bus.enable && (r_count == c_count_max);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count        <= '0;
            r_period_start <= 1'b0;
        end else if (bus.enable) begin
            r_count        <= r_count + 1'b1;
            r_period_start <= (r_count == '0);
        end else begin
            r_count        <= '0;
            r_period_start <= 1'b0;
        end
    end

    assign bus.period_start = r_period_start;

    pwm_channel #(.WIDTH(WIDTH)) u_red (
        .clk      (clk),
        .reset    (reset),
        .i_enable (bus.enable),
        .i_wrap   (w_wrap),
        .i_count  (r_count),
        .i_duty   (bus.duty_r),
        .o_pwm    (bus.pwm_r)
    );

    pwm_channel #(.WIDTH(WIDTH)) u_green (
        .clk      (clk),
        .reset    (reset),
        .i_enable (bus.enable),
        .i_wrap   (w_wrap),
        .i_count  (r_count),
        .i_duty   (bus.duty_g),
        .o_pwm    (bus.pwm_g)
    );

    pwm_channel #(.WIDTH(WIDTH)) u_blue (
        .clk      (clk),
        .reset    (reset),
        .i_enable (bus.enable),
        .i_wrap   (w_wrap),
        .i_count  (r_count),
        .i_duty   (bus.duty_b),
        .o_pwm    (bus.pwm_b)
    );

endmodule

`default_nettype wire

// File: doc/rgb_pwm.md
Name: rgb_pwm

Overview:
- Three-channel PWM generator that consumes the 8-bit values produced by the rotary-encoder stage, one value per colour.
- Drives the R/G/B LED pins.
- Duty values are double-buffered: shadow registers follow the inputs every cycle, and active registers update only at the period wrap, so an encoder change mid-period never produces a runt or glitch pulse.
- A shared free-running period counter keeps all three channels phase-aligned.

Parameters:
- width, 8, bit width of the duty inputs and the period counter; period = 2**width cycles.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset; asserting low clears all state immediately.
- enable  input  1  high = run; low = counter parked and outputs held low.
- duty_r  input  width  red duty value from the encoder stage.
- duty_g  input  width  green duty value.
- duty_b  input  width  blue duty value.
- pwm_r  output  1  red PWM output, registered.
- pwm_g  output  1  green PWM output, registered.
- pwm_b  output  1  blue PWM output, registered.
- period_start  output  1  one-cycle pulse, registered, high in the cycle where the pwm outputs reflect count 0.

Behaviour:
- Reset (reset low, async): count=0, shadow_x=0, active_x=0, pwm_x=0, period_start=0. The block leaves reset on the first clk edge after reset returns high.
- Shadow registers: shadow_x <= duty_x every cycle, regardless of enable. Input-to-shadow latency is 1 cycle.
- Counter, when enable=1: count <= count+1, wrapping from 2**width-1 to 0 (unsigned modulo arithmetic, no saturation).
- Active load when enable=1: on the edge where count==2**width-1 (the wrap edge), active_x <= shadow_x. At all other edges active_x holds.
- Output when enable=1: pwm_x <= (count < active_x), an unsigned compare using the pre-edge count and active_x. Output latency is 1 cycle from count.
- Period marker when enable=1: period_start <= (count==0).
- Duty mapping: duty 0 gives constant low. Duty N gives exactly N high cycles per 2**width-cycle period. Duty 2**width-1 gives 255 high / 1 low for width=8; 100% duty is not reachable by design. The high phase starts at period start (left-aligned).
- Effective duty latency: a duty_x change sampled into shadow before the wrap edge affects pwm_x from the first period_start pulse after that wrap. A change arriving in the same cycle as the wrap edge (shadow updates on that same edge) is deferred one full period.
- Disabled (enable=0): count <= 0, pwm_x <= 0, period_start <= 0, active_x <= shadow_x every cycle.
- Re-enable: on the first enabled edge, count is 0, so the first period begins at once with the latest duty values, and period_start pulses on the following cycle.
- Simultaneous events:
  - enable falling at the wrap edge: the disable rule wins (count=0, outputs low).
  - Duty change during the wrap cycle: handled per shadow timing above.
- Reset mid-period: outputs drop low asynchronously. Counter phase is lost, and the next period starts from count 0 with active_x=0, so outputs stay low for the first full period after reset unless enable was low.

Decomposition:
- Shared package holds the default duty width constant (8) and the PWM period derivation (2**width) for reuse by the encoder and top level.
- Natural sub-module: pwm_channel, one per colour. It holds shadow reg, active reg and output compare, and takes count, a wrap strobe and enable from the parent.
- The parent owns the single counter and period_start.

Test Plan:
- Reset/idle: hold reset low for 5 cycles with duty_r=128, then release with enable=0 → pwm_r/g/b=0, period_start=0 throughout.
- Steady duty: enable=1, duty_r=64, duty_g=0, duty_b=255 held for 3 periods → per 256-cycle period pwm_r high 64 cycles, starting at the period_start cycle; pwm_g never high; pwm_b high 255 cycles and low 1. period_start pulses every 256 cycles.
- Glitch-free update: with duty_r=200 running, change duty_r to 10 at count=50 → current period keeps 200 high cycles; next period shows 10. No pulse shorter than 10 cycles appears.
- Wrap-edge change: present a new duty_g=100 exactly in the cycle where count=255 → new value is not used in the next period; it appears one period later.
- Enable toggle: drop enable at count=120 with duty_b=200 → pwm_b low on the next cycle. Re-enable after 10 cycles with duty_b=30 → pwm_b high for exactly 30 cycles starting 1 cycle after enable, and period_start aligned with its first high cycle.
- Async reset mid-run: assert reset between clk edges at count=77 with pwm_r high → pwm_r falls before the next edge. After release, all outputs stay low for the first 256-cycle period.
